// File: rtl/e_output_port_allocator.sv
// East output port allocator: round-robin packet-granular arbitration of N/S/W/L
// onto the east crossbar path, with downstream credit tracking.
module e_output_port_allocator #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_i,
  input  logic [3:0]       valid_i,
  input  logic [3:0]       tail_i,
  input  logic             credit_return_i,
  output logic [3:0]       grant_o,
  output logic [2:0]       xbar_sel_o,
  output logic             flit_fire_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             busy_o,
  output logic             credit_err_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2:0] SEL_IDLE = 3'd3;

  state_t           state_q;
  logic [3:0]       grant_q;
  logic [2:0]       sel_q;
  logic [1:0]       rr_q;
  logic [1:0]       gord_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             pick_vld;
  logic [1:0]       pick_ord;
  logic [1:0]       ord_c;
  logic             tail_fire;

  // Ordinals 0..3 are N,S,W,L; request bit index is 3 - ordinal.
  always_comb begin
    pick_vld = 1'b0;
    pick_ord = rr_q;
    ord_c    = '0;
    for (int k = 3; k >= 0; k--) begin
      ord_c = rr_q + 2'(k);
      if (req_i[2'd3 - ord_c]) begin
        pick_vld = 1'b1;
        pick_ord = ord_c;
      end
    end
  end

  assign flit_fire_o = (state_q == ACTIVE) && (|(valid_i & grant_q)) && (cnt_q != '0);
  assign tail_fire   = flit_fire_o && (|(tail_i & grant_q));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (flit_fire_o && !credit_return_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!flit_fire_o && credit_return_i) begin
      if (cnt_q == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
      else                            cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= SEL_IDLE;
      rr_q    <= 2'd0;
      gord_q  <= 2'd0;
      cnt_q   <= CNT_W'(BUF_DEPTH);
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= ACTIVE;
            grant_q <= 4'b1000 >> pick_ord;
            sel_q   <= (pick_ord == 2'd3) ? 3'd4 : {1'b0, pick_ord};
            gord_q  <= pick_ord;
          end
        end
        ACTIVE: begin
          // Releasing requester drops to lowest priority for the next round.
          if (tail_fire) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= SEL_IDLE;
            rr_q    <= gord_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign xbar_sel_o   = sel_q;
  assign credit_cnt_o = cnt_q;
  assign busy_o       = (state_q == ACTIVE);
  assign credit_err_o = err_q;

endmodule
